stage_ex_pipe: RTL and testbench

STAGE_EX_PIPE -- requirements
Module: stage_ex_pipe

---
 rtl/stage_ex_pipe.sv | 167 ++++++++++++++++
 tb/tb_stage_ex_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_pipe.sv
// Execute stage: single-cycle ALU with a valid/ready handshake, a branch-target adder,
// and a multi-cycle shift-add multiplier that writes HI/LO.
module stage_ex_pipe #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         readRs,
  input  logic [WIDTH-1:0]         readRt,
  input  logic [WIDTH-1:0]         signExt,
  input  logic [$clog2(WIDTH)-1:0] sa,
  input  logic [5:0]               instReg,
  input  logic [PC_W-1:0]          postPc,
  input  logic                     ALUSrc,
  input  logic [1:0]               ALUOp,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         outAlu,
  output logic                     zeroAlu,
  output logic [PC_W-1:0]          outAddEx,
  output logic                     busy
);

  localparam int SA_W = $clog2(WIDTH);

  localparam logic [5:0] F_ADD  = 6'b100000, F_SUB  = 6'b100010, F_AND  = 6'b100100,
                         F_OR   = 6'b100101, F_XOR  = 6'b100110, F_NOR  = 6'b100111,
                         F_SLT  = 6'b101010, F_SLTU = 6'b101011, F_SLL  = 6'b000000,
                         F_SRL  = 6'b000010, F_SRA  = 6'b000011, F_SLLV = 6'b000100,
                         F_SRLV = 6'b000110, F_SRAV = 6'b000111, F_MULT = 6'b011000,
                         F_MULTU = 6'b011001, F_MFHI = 6'b010000, F_MFLO = 6'b010010;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, nextState;
  logic [WIDTH-1:0]     hiReg, loReg;
  logic [WIDTH-1:0]     opB, aluRes, absRs, absRt;
  logic [PC_W-1:0]      immPc, branchTgt;
  logic                 accept, isMult, isSigned, lastStep;
  logic [2*WIDTH-1:0]   mcand, acc, stepAcc, product;
  logic [WIDTH-1:0]     mplier;
  logic                 mulNeg;
  logic [SA_W-1:0]      mulCnt;

  assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign isMult   = (ALUOp == 2'b10) && (instReg == F_MULT || instReg == F_MULTU);
  assign isSigned = (instReg == F_MULT);
  assign opB      = ALUSrc ? signExt : readRt;

  // Immediate is sign-extended (or truncated) to the PC width before the word shift.
  assign immPc     = PC_W'($signed(signExt));
  assign branchTgt = postPc + (immPc << 2);

  // Signed multiply runs on magnitudes; the sign is reapplied to the full product.
  assign absRs    = (isSigned && readRs[WIDTH-1]) ? -readRs : readRs;
  assign absRt    = (isSigned && readRt[WIDTH-1]) ? -readRt : readRt;
  assign stepAcc  = acc + (mplier[0] ? mcand : '0);
  assign product  = mulNeg ? -stepAcc : stepAcc;
  assign lastStep = (mulCnt == SA_W'(WIDTH - 1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    aluRes = '0;
    case (ALUOp)
      2'b00: aluRes = readRs + opB;
      2'b01: aluRes = readRs - opB;
      2'b11: aluRes = opB << (WIDTH / 2);
      default: begin
        case (instReg)
          F_ADD:  aluRes = readRs + opB;
          F_SUB:  aluRes = readRs - opB;
          F_AND:  aluRes = readRs & opB;
          F_OR:   aluRes = readRs | opB;
          F_XOR:  aluRes = readRs ^ opB;
          F_NOR:  aluRes = ~(readRs | opB);
          F_SLT:  aluRes = {{(WIDTH-1){1'b0}}, $signed(readRs) < $signed(opB)};
          F_SLTU: aluRes = {{(WIDTH-1){1'b0}}, readRs < opB};
          F_SLL:  aluRes = opB << sa;
          F_SRL:  aluRes = opB >> sa;
          F_SRA:  aluRes = $signed(opB) >>> sa;
          F_SLLV: aluRes = readRt << readRs[SA_W-1:0];
          F_SRLV: aluRes = readRt >> readRs[SA_W-1:0];
          F_SRAV: aluRes = $signed(readRt) >>> readRs[SA_W-1:0];
          F_MFHI: aluRes = hiReg;
          F_MFLO: aluRes = loReg;
          default: aluRes = '0;
        endcase
      end
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && isMult) nextState = MUL;
      MUL:     if (lastStep) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      outAlu    <= '0;
      zeroAlu   <= 1'b0;
      outAddEx  <= '0;
      busy      <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      mulNeg    <= 1'b0;
      mulCnt    <= '0;
    end else begin
      busy <= (nextState != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            outAddEx <= branchTgt;
            if (isMult) begin
              out_valid <= 1'b0;
              mcand     <= {{WIDTH{1'b0}}, absRs};
              mplier    <= absRt;
              acc       <= '0;
              mulNeg    <= isSigned && (readRs[WIDTH-1] ^ readRt[WIDTH-1]);
              mulCnt    <= '0;
            end else begin
              out_valid <= 1'b1;
              outAlu    <= aluRes;
              zeroAlu   <= (aluRes == '0);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= stepAcc;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          mulCnt <= mulCnt + 1'b1;
          if (lastStep) begin
            hiReg     <= product[2*WIDTH-1:WIDTH];
            loReg     <= product[WIDTH-1:0];
            outAlu    <= product[WIDTH-1:0];
            zeroAlu   <= (product[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ex_pipe.sv
// Scoreboard bench for stage_ex_pipe: directed vectors push hand-computed results,
// a negedge monitor pops and compares every transferred output token.
module tb_stage_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] readRs, readRt, signExt, postPc;
  logic [4:0]  sa;
  logic [5:0]  instReg;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] outAlu, outAddEx;
  logic        zeroAlu, busy;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] addEx;
  } exp_t;

  exp_t sb[$];
  int   nTests = 0;
  int   nFail  = 0;

  stage_ex_pipe #(.WIDTH(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .readRs(readRs), .readRt(readRt), .signExt(signExt),
    .sa(sa), .instReg(instReg), .postPc(postPc), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .outAlu(outAlu), .zeroAlu(zeroAlu), .outAddEx(outAddEx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one instruction and holds it until accepted; optionally records its expected token.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] se, input logic [4:0] s,
                       input logic src, input logic [31:0] pc, input bit push,
                       input logic [31:0] expAlu, input logic [31:0] expAddEx);
    int n = 0;
    ALUOp = op; instReg = fn; readRs = rs; readRt = rt; signExt = se; sa = s;
    ALUSrc = src; postPc = pc; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      if (push) sb.push_back('{alu: expAlu, zero: (expAlu == 32'd0), addEx: expAddEx});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected token", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("outAlu", outAlu, e.alu);
        check("zeroAlu", zeroAlu, e.zero);
        check("outAddEx", outAddEx, e.addEx);
      end
    end
  end

  initial begin
    int busyCycles, badCycles, n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    readRs = '0; readRt = '0; signExt = '0; postPc = '0; sa = '0;
    instReg = '0; ALUSrc = 1'b0; ALUOp = '0;
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst outAlu", outAlu, 0);
    check("rst zeroAlu", zeroAlu, 0);
    check("rst outAddEx", outAddEx, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // sub 5-5 with latency-1 visibility check
    issue(2'b10, 6'b100010, 32'd5, 32'd5, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'h0, 32'h100);
    check("lat1 out_valid", out_valid, 1);
    check("lat1 zeroAlu", zeroAlu, 1);
    issue(2'b10, 6'b000011, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 1'b0, 32'h100, 1, 32'hF800_0000, 32'h100);
    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'd1, 32'h100);
    issue(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'd0, 32'h100);
    issue(2'b00, 6'b000000, 32'h10, 32'd99, 32'h20, 5'd0, 1'b1, 32'h100, 1, 32'h30, 32'h180);
    issue(2'b11, 6'b000000, 32'd0, 32'd0, 32'h1234, 5'd0, 1'b1, 32'h100, 1, 32'h1234_0000, 32'h49D0);
    issue(2'b01, 6'b000000, 32'd10, 32'd3, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h100, 1, 32'd7, 32'hFC);
    issue(2'b10, 6'b100100, 32'hF0F0, 32'hFF00, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'hF000, 32'h100);
    issue(2'b10, 6'b100101, 32'hF0F0, 32'hFF00, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'hFFF0, 32'h100);
    issue(2'b10, 6'b100110, 32'hF0F0, 32'hFF00, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'h0FF0, 32'h100);
    issue(2'b10, 6'b100111, 32'hF0F0, 32'hFF00, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'hFFFF_000F, 32'h100);
    issue(2'b10, 6'b000000, 32'd0, 32'd1, 32'd0, 5'd31, 1'b0, 32'h100, 1, 32'h8000_0000, 32'h100);
    issue(2'b10, 6'b000010, 32'd0, 32'h8000_0000, 32'd0, 5'd31, 1'b0, 32'h100, 1, 32'd1, 32'h100);
    issue(2'b10, 6'b000111, 32'h24, 32'h8000_0000, 32'd5, 5'd0, 1'b1, 32'h100, 1, 32'hF800_0000, 32'h114);
    issue(2'b10, 6'b111111, 32'd7, 32'd9, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'd0, 32'h100);
    issue(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'd1, 32'h100);

    // signed mult -3 x 7, then read back HI and LO
    issue(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7, 32'd0, 5'd0, 1'b1, 32'h100, 1, 32'hFFFF_FFEB, 32'h100);
    busyCycles = 0; badCycles = 0; n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      if (busy) busyCycles++;
      if (in_ready || !busy) badCycles++;
      @(negedge clk);
      n++;
    end
    check("mult busy cycles", busyCycles, 32);
    check("mult in_ready/busy during MUL", badCycles, 0);
    check("mult DONE busy", busy, 1);
    issue(2'b10, 6'b010000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'hFFFF_FFFF, 32'h100);
    issue(2'b10, 6'b010010, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'hFFFF_FFEB, 32'h100);

    // backpressure: two queued ops, first result held for 3 cycles
    @(posedge clk); #1 out_ready = 1'b0;
    fork
      begin
        issue(2'b00, 6'b000000, 32'd100, 32'd23, 32'd0, 5'd0, 1'b0, 32'h300, 1, 32'h7B, 32'h300);
        issue(2'b10, 6'b100110, 32'hAA, 32'h55, 32'd0, 5'd0, 1'b0, 32'h304, 1, 32'hFF, 32'h304);
      end
      begin
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          check("stall out_valid", out_valid, 1);
          check("stall outAlu", outAlu, 32'h7B);
          check("stall outAddEx", outAddEx, 32'h300);
          check("stall in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join

    // reset in the middle of a multu: no token, HI/LO cleared
    issue(2'b10, 6'b010000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'hFFFF_FFFF, 32'h100);
    issue(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd0, 1'b0, 32'h200, 0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort outAlu", outAlu, 0);
    check("abort zeroAlu", zeroAlu, 0);
    check("abort outAddEx", outAddEx, 0);
    check("abort busy", busy, 0);
    check("abort in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b10, 6'b010000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'd0, 32'h100);
    issue(2'b10, 6'b010010, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h100, 1, 32'd0, 32'h100);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
